// File: rtl/postproc_pkg.sv
// postproc_pkg: shared definitions for the post-processing arbiter slice.
//   - state_e     : controller state encoding (IDLE=0, ISSUE=1, WAIT=2, DELIVER=3)
//   - DefLogWidth : default log-domain sample width
//   - DefCompWidth: default compressed sample width
//   - ch_width()  : channel-tag width for a given channel count (minimum 1 bit)
package postproc_pkg;

  localparam int unsigned StateWidth   = 2;
  localparam int unsigned DefLogWidth  = 16;
  localparam int unsigned DefCompWidth = DefLogWidth / 2;

  typedef enum logic [StateWidth-1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StDeliver = 2'd3
  } state_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Searches req from index ptr upward, wrapping modulo N; first set bit wins.
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  highest-priority index for this search
//   grant out N      one-hot grant (all zero when nothing requests)
//   idx   out IDX_W  encoded index of the granted bit
//   any   out 1      at least one request present
module rr_pick
  import postproc_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = ch_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/postproc_arbiter.sv
// postproc_arbiter: shares one log-compression unit among N_CH channels.
// One sample in flight at a time: IDLE grants a channel round-robin, ISSUE
// hands the sample to the unit, WAIT collects the result (with a watchdog),
// DELIVER presents it downstream tagged with its channel.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_data     per-channel samples (channel i at [i*LOG_WIDTH +: LOG_WIDTH])
//   req_ready              one-hot accept for the granted channel (IDLE only)
//   pp_in_valid/ready      unit input handshake, pp_log_in sample to unit
//   pp_out_valid/ready     unit output handshake, pp_comp_out result from unit
//   out_valid/ready        downstream handshake, out_data result, out_ch channel tag
//   timeout_pulse          one-cycle pulse when the watchdog aborts a sample
//   busy                   high whenever not IDLE
module postproc_arbiter
  import postproc_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned LOG_WIDTH  = DefLogWidth,
  parameter int unsigned COMP_WIDTH = LOG_WIDTH / 2,
  parameter int unsigned CH_W       = ch_width(N_CH),
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           req_valid,
  input  logic [N_CH*LOG_WIDTH-1:0] req_data,
  output logic [N_CH-1:0]           req_ready,
  output logic                      pp_in_valid,
  input  logic                      pp_in_ready,
  output logic [LOG_WIDTH-1:0]      pp_log_in,
  input  logic                      pp_out_valid,
  output logic                      pp_out_ready,
  input  logic [COMP_WIDTH-1:0]     pp_comp_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COMP_WIDTH-1:0]     out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      timeout_pulse,
  output logic                      busy
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic                  pp_in_valid_q, pp_in_valid_d;
  logic [LOG_WIDTH-1:0]  pp_log_in_q, pp_log_in_d;
  logic                  out_valid_q, out_valid_d;
  logic [COMP_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic                  timeout_pulse_q, timeout_pulse_d;

  logic [N_CH-1:0]      grant;
  logic [CH_W-1:0]      grant_idx;
  logic                 grant_any;
  logic [LOG_WIDTH-1:0] sel_data;
  logic [CH_W-1:0]      next_ptr;

  rr_pick #(
    .N     (N_CH),
    .IDX_W (CH_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // One-hot OR-mux of the granted channel's sample.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) sel_data = sel_data | req_data[i*LOG_WIDTH +: LOG_WIDTH];
    end
  end

  assign next_ptr = (cur_ch_q == CH_W'(N_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    cur_ch_d        = cur_ch_q;
    wd_d            = wd_q;
    pp_in_valid_d   = pp_in_valid_q;
    pp_log_in_d     = pp_log_in_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_ch_d        = out_ch_q;
    timeout_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          pp_log_in_d   = sel_data;
          cur_ch_d      = grant_idx;
          pp_in_valid_d = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (pp_in_ready) begin
          pp_in_valid_d = 1'b0;
          wd_d          = '0;
          state_d       = StWait;
        end
      end
      StWait: begin
        // A result arriving on the terminal watchdog cycle takes priority.
        if (pp_out_valid) begin
          out_data_d  = pp_comp_out;
          out_ch_d    = cur_ch_q;
          out_valid_d = 1'b1;
          state_d     = StDeliver;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          // This cycle's increment would reach TIMEOUT: abort the sample.
          timeout_pulse_d = 1'b1;
          rr_ptr_d        = next_ptr;
          state_d         = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StDeliver: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = next_ptr;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      cur_ch_q        <= '0;
      wd_q            <= '0;
      pp_in_valid_q   <= 1'b0;
      pp_log_in_q     <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_ch_q        <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      cur_ch_q        <= cur_ch_d;
      wd_q            <= wd_d;
      pp_in_valid_q   <= pp_in_valid_d;
      pp_log_in_q     <= pp_log_in_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_ch_q        <= out_ch_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  // Ready outputs are masked during reset so no upstream transfer is lost to it.
  assign req_ready     = (state_q == StIdle && !reset) ? grant : '0;
  assign pp_out_ready  = (state_q == StWait) && !reset;
  assign busy          = (state_q != StIdle);
  assign pp_in_valid   = pp_in_valid_q;
  assign pp_log_in     = pp_log_in_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_ch        = out_ch_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_postproc_arbiter.sv
// Directed testbench for postproc_arbiter with a latency-configurable model of
// the compression unit (comp_out = upper half of log_in).
module tb_postproc_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        pp_in_valid;
  logic        pp_in_ready = 1'b1;
  logic [15:0] pp_log_in;
  logic        pp_out_valid;
  logic        pp_out_ready;
  logic [7:0]  pp_comp_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        timeout_pulse;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  postproc_arbiter #(
    .N_CH       (4),
    .LOG_WIDTH  (16),
    .COMP_WIDTH (8),
    .CH_W       (2),
    .TIMEOUT    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .pp_in_valid   (pp_in_valid),
    .pp_in_ready   (pp_in_ready),
    .pp_log_in     (pp_log_in),
    .pp_out_valid  (pp_out_valid),
    .pp_out_ready  (pp_out_ready),
    .pp_comp_out   (pp_comp_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ch        (out_ch),
    .timeout_pulse (timeout_pulse),
    .busy          (busy)
  );

  // Unit model: result valid m_lat cycles after the input handshake cycle.
  int         m_lat = 2;
  logic       m_stall = 1'b0;
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_data = '0;

  assign pp_out_valid = m_busy && (m_cnt == 0) && !m_stall;
  assign pp_comp_out  = m_data;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_data <= '0;
    end else if (pp_in_valid && pp_in_ready) begin
      m_busy <= 1'b1;
      m_data <= pp_log_in[15:8];
      m_cnt  <= m_lat - 1;
    end else if (m_busy) begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else if (pp_out_valid && pp_out_ready) m_busy <= 1'b0;
    end
  end

  // Monitor: records grants, deliveries and one-hot violations.
  int         pulses[4];
  int         onehot_err = 0;
  int         grant_q[$];
  logic [9:0] out_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if ((req_ready & (req_ready - 4'd1)) != 4'd0) onehot_err++;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          pulses[i]++;
          grant_q.push_back(i);
        end
      end
      if (out_valid && out_ready) out_q.push_back({out_ch, out_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    onehot_err = 0;
    grant_q.delete();
    out_q.delete();
  endtask

  // Leaves the caller at the negedge of the first out_valid cycle when ok.
  task automatic wait_out(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests++;
    if ({req_ready, pp_in_valid, pp_out_ready, out_valid, timeout_pulse, busy} !== 9'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy=%b piv=%b por=%b ov=%b tp=%b busy=%b want all 0",
               req_ready, pp_in_valid, pp_out_ready, out_valid, timeout_pulse, busy);
    end
    tests++;
    if ({pp_log_in, out_data, out_ch} !== 26'b0) begin
      fails++;
      $display("FAIL reset_data: got log=%h data=%h ch=%0d want 0", pp_log_in, out_data, out_ch);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || req_ready !== 4'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b rdy=%b want 0/0000", busy, req_ready);
    end
    tick();
  endtask

  task automatic test_single();
    bit ok;
    clear_mon();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    req_data[32 +: 16] = 16'hA5C3;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    tests++;
    if (pp_in_valid !== 1'b1 || pp_log_in !== 16'hA5C3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_issue: got piv=%b log=%h busy=%b want 1/a5c3/1",
               pp_in_valid, pp_log_in, busy);
    end
    tick();
    @(negedge clk);
    tests++;
    if (pp_in_valid !== 1'b0 || pp_out_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_wait: got piv=%b por=%b want 0/1", pp_in_valid, pp_out_ready);
    end
    tick();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_early: got out_valid=%b want 0", out_valid);
    end
    tick();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      fails++;
      $display("FAIL single_out: got ov=%b data=%h ch=%0d want 1/a5/2", out_valid, out_data, out_ch);
    end
    tick();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_done: got ov=%b busy=%b want 0/0", out_valid, busy);
    end
    tick();
    tests++;
    if (pulses[2] != 1 || pulses[0] + pulses[1] + pulses[3] != 0) begin
      fails++;
      $display("FAIL single_pulses: got %0d/%0d/%0d/%0d want 0/0/1/0",
               pulses[0], pulses[1], pulses[2], pulses[3]);
    end
    wait_idle(5, ok);
  endtask

  task automatic test_all_channels();
    int exp_g[6] = '{0, 1, 2, 3, 0, 1};
    bit ok;
    reset = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = {8'hC0 + 8'(i), 8'h5A};
    clear_mon();
    tick();
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0) begin
      fails++;
      $display("FAIL all_in_reset: got rdy=%b want 0000", req_ready);
    end
    tick();
    reset = 1'b0;
    for (int n = 0; n < 60 && out_q.size() < 6; n++) tick();
    req_valid = '0;
    wait_idle(20, ok);
    tests++;
    if (grant_q.size() < 6 || out_q.size() < 6) begin
      fails++;
      $display("FAIL all_count: got grants=%0d outs=%0d want >=6", grant_q.size(), out_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (grant_q[k] != exp_g[k] || out_q[k] !== {2'(exp_g[k]), 8'hC0 + 8'(exp_g[k])}) begin
          fails++;
          $display("FAIL all_order[%0d]: got grant=%0d out=%h want grant=%0d out=%h", k,
                   grant_q[k], out_q[k], exp_g[k], {2'(exp_g[k]), 8'hC0 + 8'(exp_g[k])});
        end
      end
    end
    tests++;
    if (onehot_err != 0) begin
      fails++;
      $display("FAIL all_onehot: got %0d violations want 0", onehot_err);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    clear_mon();
    out_ready = 1'b0;
    req_valid = 4'b0010;
    req_data[16 +: 16] = 16'h3C77;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL bp_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b1001;
    req_data[0 +: 16]  = 16'h0F00;
    req_data[48 +: 16] = 16'hE1F0;
    wait_out(20, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_wait: got no out_valid want out_valid within 20 cycles");
    end
    tick();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got ov=%b data=%h ch=%0d want 1/3c/1",
                 c, out_valid, out_data, out_ch);
      end
      tests++;
      if (busy !== 1'b1 || req_ready !== 4'b0) begin
        fails++;
        $display("FAIL bp_block[%0d]: got busy=%b rdy=%b want 1/0000", c, busy, req_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL bp_release: got ov=%b rdy=%b want 0/1000", out_valid, req_ready);
    end
    tick();
    req_valid = '0;
    wait_out(20, ok);
    tests++;
    if (!ok || out_ch !== 2'd3 || out_data !== 8'hE1) begin
      fails++;
      $display("FAIL bp_next: got ok=%b ch=%0d data=%h want 1/3/e1", ok, out_ch, out_data);
    end
    tick();
    wait_idle(10, ok);
    tests++;
    if (out_q.size() != 2 || out_q[0] !== {2'd1, 8'h3C}) begin
      fails++;
      $display("FAIL bp_log: got n=%0d first=%h want 2/13c", out_q.size(), out_q[0]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mon();
    m_stall = 1'b1;
    req_valid = 4'b0011;
    req_data[0 +: 16]  = 16'h1111;
    req_data[16 +: 16] = 16'h2222;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL to_grant: got %b want 0001", req_ready);
    end
    tick();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      tests++;
      if (timeout_pulse !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL to_early[%0d]: got tp=%b ov=%b want 0/0", c, timeout_pulse, out_valid);
      end
      tick();
    end
    @(negedge clk);
    tests++;
    if (timeout_pulse !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL to_pulse: got tp=%b ov=%b want 1/0", timeout_pulse, out_valid);
    end
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL to_rr: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    m_stall = 1'b0;
    @(negedge clk);
    tests++;
    if (timeout_pulse !== 1'b0) begin
      fails++;
      $display("FAIL to_single: got tp=%b want 0", timeout_pulse);
    end
    tick();
    wait_out(20, ok);
    tests++;
    if (!ok || out_ch !== 2'd1 || out_data !== 8'h22) begin
      fails++;
      $display("FAIL to_next: got ok=%b ch=%0d data=%h want 1/1/22", ok, out_ch, out_data);
    end
    tick();
    wait_idle(10, ok);
  endtask

  task automatic test_terminal();
    bit ok;
    m_lat = 8;
    req_valid = 4'b0100;
    req_data[32 +: 16] = 16'h7E01;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL term_grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      tests++;
      if (timeout_pulse !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL term_early[%0d]: got tp=%b ov=%b want 0/0", c, timeout_pulse, out_valid);
      end
      tick();
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h7E || out_ch !== 2'd2 || timeout_pulse !== 1'b0) begin
      fails++;
      $display("FAIL term_out: got ov=%b data=%h ch=%0d tp=%b want 1/7e/2/0",
               out_valid, out_data, out_ch, timeout_pulse);
    end
    tick();
    wait_idle(10, ok);
    m_lat = 2;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    m_stall = 1'b1;
    req_valid = 4'b0010;
    req_data[16 +: 16] = 16'h4444;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL mid_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    req_valid = 4'b1000;
    req_data[48 +: 16] = 16'h5AFF;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || req_ready !== 4'b0) begin
      fails++;
      $display("FAIL mid_inflight: got busy=%b rdy=%b want 1/0000", busy, req_ready);
    end
    tick();
    reset = 1'b0;
    m_stall = 1'b0;
    @(negedge clk);
    tests++;
    if ({pp_in_valid, pp_out_ready, out_valid, timeout_pulse, busy} !== 5'b0 ||
        {pp_log_in, out_data, out_ch} !== 26'b0) begin
      fails++;
      $display("FAIL mid_reset_vals: got piv=%b por=%b ov=%b tp=%b busy=%b log=%h data=%h ch=%0d",
               pp_in_valid, pp_out_ready, out_valid, timeout_pulse, busy, pp_log_in, out_data,
               out_ch);
    end
    tests++;
    if (req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL mid_regrant: got %b want 1000", req_ready);
    end
    tick();
    req_valid = '0;
    wait_out(20, ok);
    tests++;
    if (!ok || out_ch !== 2'd3 || out_data !== 8'h5A) begin
      fails++;
      $display("FAIL mid_out: got ok=%b ch=%0d data=%h want 1/3/5a", ok, out_ch, out_data);
    end
    tick();
    wait_idle(10, ok);
    tests++;
    if (out_q.size() != 1) begin
      fails++;
      $display("FAIL mid_count: got %0d outputs want 1", out_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_back_pressure();
    test_timeout();
    test_terminal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
